// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the banked shared buffer:
//   - clog2()        : bank-select width helper
//   - prio_e         : arbiter priority flag encoding (PRIO_WR=0, PRIO_RD=1)
//   - READ_LAT_MIN/MAX, readLatLegal() : READ_LAT legality check
// No ports (package).
// -----------------------------------------------------------------------------
package sb_pkg;

   // Which port wins the next same-bank conflict
   typedef enum logic {
      PRIO_WR = 1'b0,
      PRIO_RD = 1'b1
   } prio_e;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   // Ceiling log2, used to size the bank-select field of an address
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >>> 1;
      end
      return result;
   endfunction

   // Only the bare bank latency (1) or bank plus output register (2) exist
   function automatic bit readLatLegal(input int lat);
      return (lat == READ_LAT_MIN) || (lat == READ_LAT_MAX);
   endfunction

endpackage

// File: rtl/sb_bank.sv
// -----------------------------------------------------------------------------
// sb_bank
// Single-port synchronous RAM bank with a registered read (1-cycle latency).
// Contents are not reset.
// Optional byte-mask port BE exists only when SB_BYTE_WE_EN is defined.
//
// Ports:
//   CLK  in  1          clock
//   CEN  in  1          chip enable; no access when low
//   WEN  in  1          1 = write, 0 = read (when CEN=1)
//   A    in  IDX_W      bank-local word index
//   D    in  DATA_W     write data
//   BE   in  DATA_W/8   byte write mask (SB_BYTE_WE_EN only)
//   Q    out DATA_W     read data, updated the cycle after a read access
// -----------------------------------------------------------------------------
module sb_bank #(
   parameter int DATA_W = 512,
   parameter int IDX_W  = 11
) (
   input  logic              CLK,
   input  logic              CEN,
   input  logic              WEN,
   input  logic [IDX_W-1:0]  A,
   input  logic [DATA_W-1:0] D,
`ifdef SB_BYTE_WE_EN
   input  logic [DATA_W/8-1:0] BE,
`endif
   output logic [DATA_W-1:0] Q
);

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [DATA_W-1:0] rdata_q;

   // One access per cycle: a write updates the array, a read captures the
   // addressed word into the output register. The read register holds its
   // value on write or idle cycles; the top level only looks at it on the
   // cycle after a read it issued.
   always_ff @(posedge CLK) begin
      if (CEN) begin
         if (WEN) begin
`ifdef SB_BYTE_WE_EN
            for (int b = 0; b < DATA_W/8; b++) begin
               if (BE[b]) begin
                  mem_q[A][8*b +: 8] <= D[8*b +: 8];
               end
            end
`else
            mem_q[A] <= D;
`endif
         end else begin
            rdata_q <= mem_q[A];
         end
      end
   end

   assign Q = rdata_q;

endmodule

// File: rtl/shared_buffer_banked.sv
// -----------------------------------------------------------------------------
// shared_buffer_banked
// Banked shared buffer with one write port (DMA side) and one read port
// (systolic-array feeder side). Storage is split into NUM_BANKS single-port
// banks interleaved on the low address bits, so a write and a read proceed
// in the same cycle whenever they target different banks. Same-bank
// conflicts are settled by an alternating-priority flag.
//
// Optional feature: define SB_BYTE_WE_EN to add the WBE byte-enable port.
//
// Ports:
//   CLK     in  1          clock, rising edge
//   RST     in  1          synchronous active-high reset
//   RETN    in  1          retention enable; 0 = no new accesses
//   WREQ    in  1          write request
//   WREADY  out 1          write accepted when WREQ & WREADY
//   WADDR   in  ADDR_W     write word address
//   WDATA   in  DATA_W     write data
//   WBE     in  DATA_W/8   byte enables (SB_BYTE_WE_EN only)
//   RREQ    in  1          read request
//   RREADY  out 1          read accepted when RREQ & RREADY
//   RADDR   in  ADDR_W     read word address
//   Q       out DATA_W     read data, 0 when QVALID=0
//   QVALID  out 1          Q carries data of an accepted read
// -----------------------------------------------------------------------------
module shared_buffer_banked
   import sb_pkg::*;
#(
   parameter int DATA_W    = 512,
   parameter int ADDR_W    = 13,
   parameter int NUM_BANKS = 4,
   parameter int READ_LAT  = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RETN,
   input  logic              WREQ,
   output logic              WREADY,
   input  logic [ADDR_W-1:0] WADDR,
   input  logic [DATA_W-1:0] WDATA,
`ifdef SB_BYTE_WE_EN
   input  logic [DATA_W/8-1:0] WBE,
`endif
   input  logic              RREQ,
   output logic              RREADY,
   input  logic [ADDR_W-1:0] RADDR,
   output logic [DATA_W-1:0] Q,
   output logic              QVALID
);

   localparam int BANK_W = clog2(NUM_BANKS);
   localparam int IDX_W  = ADDR_W - BANK_W;

   // An illegal latency falls back to the bare 1-cycle bank path
   localparam bit OUT_REG_EN = readLatLegal(READ_LAT) && (READ_LAT == READ_LAT_MAX);

   logic [BANK_W-1:0] wBank, rBank;
   logic [IDX_W-1:0]  wIdx, rIdx;
   logic              conflict;
   logic              wAcc, rAcc;

   prio_e             prio_q, prio_d;

   logic              rValid_q;
   logic [BANK_W-1:0] rBank_q;

   logic [DATA_W-1:0] bankQ [NUM_BANKS];
   logic [DATA_W-1:0] bankData;

   assign wBank = WADDR[BANK_W-1:0];
   assign rBank = RADDR[BANK_W-1:0];
   assign wIdx  = WADDR[ADDR_W-1:BANK_W];
   assign rIdx  = RADDR[ADDR_W-1:BANK_W];

   // Arbiter: both ports are ready unless the buffer is idle (RETN=0) or both
   // request the same bank. On a conflict the flagged port wins and the flag
   // flips, so the loser is guaranteed the next conflict cycle.
   always_comb begin
      conflict = RETN && WREQ && RREQ && (wBank == rBank);
      WREADY   = RETN;
      RREADY   = RETN;
      prio_d   = prio_q;
      if (conflict) begin
         if (prio_q == PRIO_WR) begin
            RREADY = 1'b0;
            prio_d = PRIO_RD;
         end else begin
            WREADY = 1'b0;
            prio_d = PRIO_WR;
         end
      end
   end

   assign wAcc = WREQ && WREADY;
   assign rAcc = RREQ && RREADY;

   // Priority flag plus the read-valid/bank-id stage that tracks which bank
   // holds the data of last cycle's read. Reset drops any read in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         prio_q   <= PRIO_WR;
         rValid_q <= 1'b0;
         rBank_q  <= '0;
      end else begin
         prio_q   <= prio_d;
         rValid_q <= rAcc;
         rBank_q  <= rBank;
      end
   end

   // Each bank sees at most one access: the arbiter never accepts a write and
   // a read to the same bank in one cycle, so the address mux is safe.
   for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
      logic wHit, rHit;
      assign wHit = wAcc && (wBank == BANK_W'(g));
      assign rHit = rAcc && (rBank == BANK_W'(g));

      sb_bank #(
         .DATA_W(DATA_W),
         .IDX_W (IDX_W)
      ) uBank (
         .CLK(CLK),
         .CEN(wHit || rHit),
         .WEN(wHit),
         .A  (wHit ? wIdx : rIdx),
         .D  (WDATA),
`ifdef SB_BYTE_WE_EN
         .BE (WBE),
`endif
         .Q  (bankQ[g])
      );
   end

   // Bank outputs hold stale words, so the selected data is forced to zero
   // unless a read actually completes this cycle.
   assign bankData = rValid_q ? bankQ[rBank_q] : '0;

   if (OUT_REG_EN) begin : gOutReg
      logic [DATA_W-1:0] q_q;
      logic              qValid_q;

      // Extra output stage for timing; it already carries zero data when idle
      always_ff @(posedge CLK) begin
         if (RST) begin
            q_q      <= '0;
            qValid_q <= 1'b0;
         end else begin
            q_q      <= bankData;
            qValid_q <= rValid_q;
         end
      end

      assign Q      = q_q;
      assign QVALID = qValid_q;
   end else begin : gNoOutReg
      assign Q      = bankData;
      assign QVALID = rValid_q;
   end

endmodule

// File: tb/tb_shared_buffer_banked.sv
// -----------------------------------------------------------------------------
// tb_shared_buffer_banked
// Bench for shared_buffer_banked (READ_LAT=2, 4 banks, 512-bit words).
// -----------------------------------------------------------------------------
module tb_shared_buffer_banked;

   localparam int DW = 512;
   localparam int AW = 13;
   localparam int NB = 4;
   localparam int RL = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RETN;
   logic          WREQ;
   logic          WREADY;
   logic [AW-1:0] WADDR;
   logic [DW-1:0] WDATA;
   logic          RREQ;
   logic          RREADY;
   logic [AW-1:0] RADDR;
   logic [DW-1:0] Q;
   logic          QVALID;
`ifdef SB_BYTE_WE_EN
   logic [DW/8-1:0] WBE;
`endif
   logic [DW/8-1:0] beEff;

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;
   bit checkEn     = 1'b0;

   // Reference state: word array, per-word "known" flag, priority flag and
   // the list of reads still owed to the consumer with their due cycles.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      bit            known;
   } rd_t;

   logic [DW-1:0] mem   [2**AW];
   bit            known [2**AW];
   bit            prioRd = 1'b0;
   rd_t           pend[$];

   shared_buffer_banked #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_BANKS(NB),
      .READ_LAT (RL)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .RETN  (RETN),
      .WREQ  (WREQ),
      .WREADY(WREADY),
      .WADDR (WADDR),
      .WDATA (WDATA),
`ifdef SB_BYTE_WE_EN
      .WBE   (WBE),
`endif
      .RREQ  (RREQ),
      .RREADY(RREADY),
      .RADDR (RADDR),
      .Q     (Q),
      .QVALID(QVALID)
   );

`ifdef SB_BYTE_WE_EN
   assign beEff = WBE;
`else
   assign beEff = '1;
`endif

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] pattern(input logic [7:0] b);
      return {64{b}};
   endfunction

   function automatic logic [DW-1:0] randWord();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   // Same bank means equal address modulo the bank count
   function automatic bit isConflict();
      return RETN && WREQ && RREQ && ((int'(WADDR) % NB) == (int'(RADDR) % NB));
   endfunction

   function automatic bit expWReady();
      return RETN && !(isConflict() && prioRd);
   endfunction

   function automatic bit expRReady();
      return RETN && !(isConflict() && !prioRd);
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit wreq, input int waddr, input logic [DW-1:0] wdata,
                                input logic [DW/8-1:0] be, input bit rreq, input int raddr,
                                input bit retn);
      WREQ  = wreq;
      WADDR = AW'(waddr);
      WDATA = wdata;
`ifdef SB_BYTE_WE_EN
      WBE   = be;
`endif
      RREQ  = rreq;
      RADDR = AW'(raddr);
      RETN  = retn;
   endtask

   task automatic idle();
      applyStimulus(0, 0, '0, '0, 0, 0, 1);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic atCycle(input int c);
      @(negedge CLK);
      while (cyc < c) @(negedge CLK);
   endtask

   // Hold the request until the handshake completes (bounded)
   task automatic waitAccept(input bit isWrite, output int accCyc);
      bit ok = 1'b0;
      int n  = 0;
      accCyc = -1;
      while (!ok && n < 8) begin
         @(negedge CLK);
         ok = isWrite ? WREADY : RREADY;
         accCyc = cyc;
         step();
         n++;
      end
      if (!ok) checkOutput("handshake timeout", 0, 1);
      idle();
   endtask

   task automatic doWrite(input int addr, input logic [DW-1:0] data, input logic [DW/8-1:0] be);
      int acc;
      applyStimulus(1, addr, data, be, 0, 0, 1);
      waitAccept(1, acc);
   endtask

   task automatic doRead(input int addr, output int acc);
      applyStimulus(0, 0, '0, '0, 1, addr, 1);
      waitAccept(0, acc);
   endtask

   // Reference update at each rising edge
   always @(posedge CLK) begin
      if (RST) begin
         prioRd = 1'b0;
         pend.delete();
      end else begin
         bit conf, wAcc, rAcc;
         conf = isConflict();
         wAcc = WREQ && expWReady();
         rAcc = RREQ && expRReady();
         if (rAcc) pend.push_back('{due: cyc + RL, data: mem[RADDR], known: known[RADDR]});
         if (wAcc) begin
            for (int b = 0; b < DW/8; b++)
               if (beEff[b]) mem[WADDR][8*b +: 8] = WDATA[8*b +: 8];
            if (&beEff) known[WADDR] = 1'b1;
         end
         if (conf) prioRd = !prioRd;
      end
      cyc++;
   end

   // Compare DUT against the reference every cycle once reset has been seen
   always @(negedge CLK) begin
      if (checkEn) begin
         checkOutput("wready", DW'(WREADY), DW'(expWReady()));
         checkOutput("rready", DW'(RREADY), DW'(expRReady()));
         if (pend.size() > 0 && pend[0].due == cyc) begin
            checkOutput("qvalid", DW'(QVALID), DW'(1));
            if (pend[0].known) checkOutput("q", Q, pend[0].data);
            void'(pend.pop_front());
         end else begin
            checkOutput("qvalid idle", DW'(QVALID), DW'(0));
            checkOutput("q idle", Q, '0);
         end
      end
   end

   initial begin
      int acc;
      bit wHold, rHold;
      logic [DW-1:0] e;

      for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
      idle();
      RST = 1'b1;
      step();
      checkEn = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("reset qvalid", DW'(QVALID), DW'(0));
      checkOutput("reset q", Q, '0);
      step();

      // Write then read the same word on the next cycle
      doWrite(5, pattern(8'hA5), '1);
      doRead(5, acc);
      atCycle(acc + RL - 1);
      checkOutput("t1 early qvalid", DW'(QVALID), DW'(0));
      atCycle(acc + RL);
      checkOutput("t1 qvalid", DW'(QVALID), DW'(1));
      checkOutput("t1 q", Q, pattern(8'hA5));
      atCycle(acc + RL + 1);
      checkOutput("t1 late qvalid", DW'(QVALID), DW'(0));
      checkOutput("t1 late q", Q, '0);
      step();

      // Different banks in the same cycle
      doWrite(1, pattern(8'h11), '1);
      applyStimulus(1, 4, pattern(8'h44), '1, 1, 1, 1);
      @(negedge CLK);
      checkOutput("t2 wready", DW'(WREADY), DW'(1));
      checkOutput("t2 rready", DW'(RREADY), DW'(1));
      acc = cyc;
      step();
      idle();
      atCycle(acc + RL);
      checkOutput("t2 q", Q, pattern(8'h11));
      step();

      // Persistent conflict alternates W,R,W,R
      applyStimulus(1, 8, pattern(8'h88), '1, 1, 12, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checkOutput("t3 wready", DW'(WREADY), DW'(k % 2 == 0));
         checkOutput("t3 rready", DW'(RREADY), DW'(k % 2 == 1));
         step();
      end
      idle();
      repeat (RL + 1) step();

      // 16 back-to-back reads
      for (int i = 0; i < 16; i++) doWrite(i, pattern(8'(48 + i)), '1);
      for (int i = 0; i < 16 + RL; i++) begin
         if (i < 16) applyStimulus(0, 0, '0, '0, 1, i, 1);
         else idle();
         @(negedge CLK);
         if (i < 16) checkOutput("t4 rready", DW'(RREADY), DW'(1));
         if (i >= RL) begin
            checkOutput("t4 qvalid", DW'(QVALID), DW'(1));
            checkOutput("t4 q", Q, pattern(8'(48 + i - RL)));
         end else begin
            checkOutput("t4 lead qvalid", DW'(QVALID), DW'(0));
         end
         step();
      end
      @(negedge CLK);
      checkOutput("t4 tail qvalid", DW'(QVALID), DW'(0));
      step();

      // One conflict leaves the flag at read, then reads dropped by reset
      applyStimulus(1, 20, pattern(8'h77), '1, 1, 24, 1);
      @(negedge CLK);
      checkOutput("t5 pre wready", DW'(WREADY), DW'(1));
      step();
      applyStimulus(0, 0, '0, '0, 1, 2, 1);
      @(negedge CLK);
      checkOutput("t5 rready a", DW'(RREADY), DW'(1));
      step();
      applyStimulus(0, 0, '0, '0, 1, 3, 1);
      @(negedge CLK);
      checkOutput("t5 rready b", DW'(RREADY), DW'(1));
      step();
      idle();
      RST = 1'b1;
      step();
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checkOutput("t5 dropped qvalid", DW'(QVALID), DW'(0));
         step();
      end
      applyStimulus(1, 20, pattern(8'h55), '1, 1, 24, 1);
      @(negedge CLK);
      checkOutput("t5 post-reset wready", DW'(WREADY), DW'(1));
      checkOutput("t5 post-reset rready", DW'(RREADY), DW'(0));
      step();
      idle();
      doRead(3, acc);
      atCycle(acc + RL);
      checkOutput("t5 reread q", Q, pattern(8'h33));
      step();

      // RETN=0 blocks new accesses but lets an accepted read finish
      applyStimulus(0, 0, '0, '0, 1, 2, 1);
      @(negedge CLK);
      acc = cyc;
      step();
      applyStimulus(1, 6, pattern(8'hEE), '1, 1, 7, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         checkOutput("retn wready", DW'(WREADY), DW'(0));
         checkOutput("retn rready", DW'(RREADY), DW'(0));
         if (cyc == acc + RL) begin
            checkOutput("retn qvalid", DW'(QVALID), DW'(1));
            checkOutput("retn q", Q, pattern(8'h32));
         end
         step();
      end
      idle();
      doRead(6, acc);
      atCycle(acc + RL);
      checkOutput("retn no write", Q, pattern(8'h36));
      step();

`ifdef SB_BYTE_WE_EN
      // Partial byte write
      doWrite(16, '0, '1);
      doWrite(16, '1, 64'h0000_0000_0000_00F0);
      doRead(16, acc);
      atCycle(acc + RL);
      e = '0;
      e[63:32] = 32'hFFFF_FFFF;
      checkOutput("t6 byte mask", Q, e);
      step();
`endif

      // Randomized traffic on a small address window to force conflicts
      wHold = 1'b0;
      rHold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         RETN = ($urandom_range(0, 9) != 0);
         if (!wHold) begin
            WREQ  = $urandom_range(0, 1) == 1;
            WADDR = AW'($urandom_range(0, 31));
            WDATA = randWord();
`ifdef SB_BYTE_WE_EN
            WBE   = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
`endif
         end
         if (!rHold) begin
            RREQ  = $urandom_range(0, 1) == 1;
            RADDR = AW'($urandom_range(0, 31));
         end
         @(negedge CLK);
         wHold = WREQ && !WREADY;
         rHold = RREQ && !RREADY;
         step();
      end
      idle();
      repeat (RL + 2) step();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
